// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and redirect controller for a 5-stage in-order pipeline.
//
// Purpose:
//   Produces per-stage hold (stall_o) and bubble (flush_o) vectors, a one-cycle
//   PC redirect strobe, saturating stall/flush performance counters and a
//   sticky data-memory timeout flag. It arbitrates between data-memory stalls,
//   taken branches, load-use hazards and fetch stalls.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   id_reg1_read/id_reg2_read    decode stage reads rs1/rs2
//   id_reg1_addr/id_reg2_addr    decode source register addresses
//   ex_is_load, ex_wreg, ex_wd   EX instruction is a load / writes rd / rd index
//   ex_branch_taken/_target      EX resolved a taken control transfer and its target
//   if_req_stall, mem_req_stall  fetch not ready / data memory busy
//   stall_o[5:0]                 hold: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, reserved
//   flush_o[1:0]                 bubble: IF/ID, ID/EX
//   redirect_o, redirect_pc_o    PC load strobe and PC value
//   state_o, timeout_err_o       FSM state, sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o     saturating counters of stall/flush cycles
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg1_read,
  input  logic              id_reg2_read,
  input  logic [4:0]        id_reg1_addr,
  input  logic [4:0]        id_reg2_addr,
  input  logic              ex_is_load,
  input  logic              ex_wreg,
  input  logic [4:0]        ex_wd,
  input  logic              ex_branch_taken,
  input  logic [31:0]       ex_branch_target,
  input  logic              if_req_stall,
  input  logic              mem_req_stall,
  output logic [5:0]        stall_o,
  output logic [1:0]        flush_o,
  output logic              redirect_o,
  output logic [31:0]       redirect_pc_o,
  output logic [1:0]        state_o,
  output logic              timeout_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] REDIR   = 2'd2;
  localparam logic [1:0] LDSTALL = 2'd3;

  localparam int MW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [MW-1:0] MEM_MAX = MW'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [MW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             timeout_q, timeout_d;

  logic [5:0] stall_c;
  logic [1:0] flush_c;
  logic       redirect_c;
  logic       load_use;
  logic       branch_ok;

  assign load_use = ex_is_load && ex_wreg && (ex_wd != 5'd0) &&
                    ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                     (id_reg2_read && (id_reg2_addr == ex_wd)));

  // In REDIR and LDSTALL the EX slot already holds a bubble, so a branch
  // indication there is stale and must not be captured.
  assign branch_ok = ex_branch_taken && ((state_q == RUN) || (state_q == MEMWAIT));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    stall_c    = 6'b000000;
    flush_c    = 2'b00;
    redirect_c = 1'b0;

    if (mem_req_stall) begin
      // Freeze everything up to MEM/WB; a branch seen now is remembered and
      // replayed as a redirect once memory releases the pipeline.
      stall_c = 6'b011111;
      state_d = MEMWAIT;
      if (branch_ok && !pend_q) begin
        pend_d    = 1'b1;
        pend_pc_d = ex_branch_target;
      end
    end else begin
      case (state_q)
        RUN, MEMWAIT: begin
          if (pend_q) begin
            // Only reachable leaving MEMWAIT: the deferred redirect fires next.
            state_d = REDIR;
          end else if (ex_branch_taken) begin
            flush_c   = 2'b11;
            pend_d    = 1'b1;
            pend_pc_d = ex_branch_target;
            state_d   = REDIR;
          end else if (load_use) begin
            stall_c = 6'b000011;
            flush_c = 2'b10;
            state_d = LDSTALL;
          end else begin
            state_d = RUN;
            if (if_req_stall) begin
              stall_c = 6'b000001;
              flush_c = 2'b01;
            end
          end
        end
        REDIR: begin
          redirect_c = 1'b1;
          flush_c    = 2'b01;
          pend_d     = 1'b0;
          state_d    = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    // Control outputs stay quiet while reset is held, whatever the inputs do.
    if (rst) begin
      stall_c    = 6'b000000;
      flush_c    = 2'b00;
      redirect_c = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mem_cnt_d   = '0;
    if ((stall_c != 6'b000000) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((flush_c != 2'b00) && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    // Run length of consecutive memory stalls, saturating at the limit.
    if (mem_req_stall) begin
      mem_cnt_d = (mem_cnt_q >= MEM_MAX) ? mem_cnt_q : mem_cnt_q + MW'(1);
    end
    timeout_d = timeout_q || (mem_cnt_d >= MEM_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      pend_pc_q   <= 32'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_o       = stall_c;
  assign flush_o       = flush_c;
  assign redirect_o    = redirect_c;
  assign redirect_pc_o = pend_pc_q;
  assign state_o       = state_q;
  assign timeout_err_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with small parameters so that
// timeout and counter saturation are reachable quickly.
module tb_pipe_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          id_reg1_read, id_reg2_read;
  logic [4:0]    id_reg1_addr, id_reg2_addr;
  logic          ex_is_load, ex_wreg;
  logic [4:0]    ex_wd;
  logic          ex_branch_taken;
  logic [31:0]   ex_branch_target;
  logic          if_req_stall, mem_req_stall;
  logic [5:0]    stall_o;
  logic [1:0]    flush_o;
  logic          redirect_o;
  logic [31:0]   redirect_pc_o;
  logic [1:0]    state_o;
  logic          timeout_err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_wd(ex_wd),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .if_req_stall(if_req_stall), .mem_req_stall(mem_req_stall),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .state_o(state_o),
    .timeout_err_o(timeout_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        r1rd, r2rd;
    logic [4:0]  a1, a2;
    logic        ld, wreg;
    logic [4:0]  wd;
    logic        br;
    logic [31:0] tgt;
    logic        ifs, mem;
  } stim_t;

  typedef struct packed {
    logic          regs_known;
    logic [5:0]    stall;
    logic [1:0]    flush;
    logic          red;
    logic [31:0]   pc;
    logic [1:0]    state;
    logic [CW-1:0] scnt, fcnt;
    logic          tout;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model: pipeline situation tracked as plain flags and a queue
  // holding at most one deferred redirect target.
  logic        m_known = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_pend[$];
  logic        m_redirect_now = 1'b0;
  logic        m_ld_bubble = 1'b0;
  logic        m_mem_wait = 1'b0;
  int          m_scnt = 0, m_fcnt = 0, m_run = 0;
  logic        m_tout = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, req);
    end
  endtask

  task automatic modelStep(input stim_t s);
    exp_t e;
    logic lu, br_seen, nxt_redir, nxt_ld, nxt_mem;
    e = '0;
    e.regs_known = m_known;
    e.pc    = m_pc;
    e.state = m_redirect_now ? 2'd2 : (m_ld_bubble ? 2'd3 : (m_mem_wait ? 2'd1 : 2'd0));
    e.scnt  = CW'(m_scnt);
    e.fcnt  = CW'(m_fcnt);
    e.tout  = m_tout;
    lu = s.ld && s.wreg && (s.wd != 5'd0) &&
         ((s.r1rd && s.a1 == s.wd) || (s.r2rd && s.a2 == s.wd));
    br_seen   = s.br && !m_redirect_now && !m_ld_bubble;
    nxt_redir = 1'b0;
    nxt_ld    = 1'b0;
    nxt_mem   = 1'b0;
    if (s.mem) begin
      e.stall = 6'b011111;
      nxt_mem = 1'b1;
      if (br_seen && m_pend.size() == 0) begin
        m_pend.push_back(s.tgt);
        m_pc = s.tgt;
      end
    end else if (m_redirect_now) begin
      e.red   = 1'b1;
      e.flush = 2'b01;
      m_pend.delete();
    end else if (m_ld_bubble) begin
      e.stall = 6'b000000;
    end else if (m_pend.size() != 0) begin
      nxt_redir = 1'b1;
    end else if (s.br) begin
      e.flush = 2'b11;
      m_pend.push_back(s.tgt);
      m_pc = s.tgt;
      nxt_redir = 1'b1;
    end else if (lu) begin
      e.stall = 6'b000011;
      e.flush = 2'b10;
      nxt_ld  = 1'b1;
    end else if (s.ifs) begin
      e.stall = 6'b000001;
      e.flush = 2'b01;
    end

    if (s.rst) begin
      e.stall = '0;
      e.flush = '0;
      e.red   = 1'b0;
      m_known = 1'b1;
      m_pc    = 32'd0;
      m_pend.delete();
      m_redirect_now = 1'b0;
      m_ld_bubble    = 1'b0;
      m_mem_wait     = 1'b0;
      m_scnt = 0;
      m_fcnt = 0;
      m_run  = 0;
      m_tout = 1'b0;
    end else begin
      m_redirect_now = nxt_redir;
      m_ld_bubble    = nxt_ld;
      m_mem_wait     = nxt_mem;
      if (e.stall != 0 && m_scnt < CMAX) m_scnt++;
      if (e.flush != 0 && m_fcnt < CMAX) m_fcnt++;
      if (s.mem) begin
        if (m_run < TO) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= TO) m_tout = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    rst              = s.rst;
    id_reg1_read     = s.r1rd;
    id_reg2_read     = s.r2rd;
    id_reg1_addr     = s.a1;
    id_reg2_addr     = s.a2;
    ex_is_load       = s.ld;
    ex_wreg          = s.wreg;
    ex_wd            = s.wd;
    ex_branch_taken  = s.br;
    ex_branch_target = s.tgt;
    if_req_stall     = s.ifs;
    mem_req_stall    = s.mem;
    modelStep(s);
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Monitor: outputs are valid every cycle, one expectation per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("stall_o", 32'(stall_o), 32'(e.stall));
        checkOutput("flush_o", 32'(flush_o), 32'(e.flush));
        checkOutput("redirect_o", 32'(redirect_o), 32'(e.red));
        if (e.regs_known) begin
          checkOutput("state_o", 32'(state_o), 32'(e.state));
          checkOutput("redirect_pc_o", redirect_pc_o, e.pc);
          checkOutput("stall_cnt_o", 32'(stall_cnt_o), 32'(e.scnt));
          checkOutput("flush_cnt_o", 32'(flush_cnt_o), 32'(e.fcnt));
          checkOutput("timeout_err_o", 32'(timeout_err_o), 32'(e.tout));
        end
      end
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    id_reg1_read = 1'b0; id_reg2_read = 1'b0;
    id_reg1_addr = 5'd0; id_reg2_addr = 5'd0;
    ex_is_load = 1'b0; ex_wreg = 1'b0; ex_wd = 5'd0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'd0;
    if_req_stall = 1'b0; mem_req_stall = 1'b0;

    $display("[TB] reset");
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    #3;
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    checkOutput("reset_redirect_pc", redirect_pc_o, 32'd0);
    checkOutput("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);

    $display("[TB] load-use");
    s = idleStim(); s.ld = 1; s.wreg = 1; s.wd = 5'd5; s.r2rd = 1; s.a2 = 5'd5;
    applyStimulus(s);
    #3;
    checkOutput("lu_stall", 32'(stall_o), 32'b000011);
    checkOutput("lu_flush", 32'(flush_o), 32'b10);
    applyStimulus(idleStim());
    #3;
    checkOutput("lu_state_ldstall", 32'(state_o), 32'd3);
    checkOutput("lu_release_stall", 32'(stall_o), 32'd0);
    s = idleStim(); s.ld = 1; s.wreg = 1; s.wd = 5'd0; s.r2rd = 1; s.a2 = 5'd0;
    applyStimulus(s);
    #3;
    checkOutput("lu_x0_state", 32'(state_o), 32'd0);
    checkOutput("lu_x0_nostall", 32'(stall_o), 32'd0);

    $display("[TB] branch");
    s = idleStim(); s.br = 1; s.tgt = 32'h100;
    applyStimulus(s);
    #3;
    checkOutput("br_flush", 32'(flush_o), 32'b11);
    applyStimulus(idleStim());
    #3;
    checkOutput("br_redirect", 32'(redirect_o), 32'd1);
    checkOutput("br_redirect_pc", redirect_pc_o, 32'h100);
    checkOutput("br_redir_flush", 32'(flush_o), 32'b01);
    applyStimulus(idleStim());
    #3;
    checkOutput("br_back_run", 32'(state_o), 32'd0);
    checkOutput("br_single_redirect", 32'(redirect_o), 32'd0);

    $display("[TB] branch during memory stall");
    s = idleStim(); s.mem = 1; s.br = 1; s.tgt = 32'h200;
    applyStimulus(s);
    #3;
    checkOutput("mb_stall_c1", 32'(stall_o), 32'b011111);
    s = idleStim(); s.mem = 1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(s);
      #3;
      checkOutput("mb_stall", 32'(stall_o), 32'b011111);
      checkOutput("mb_no_redirect", 32'(redirect_o), 32'd0);
    end
    applyStimulus(idleStim());
    #3;
    checkOutput("mb_release_stall", 32'(stall_o), 32'd0);
    checkOutput("mb_release_redirect", 32'(redirect_o), 32'd0);
    checkOutput("mb_no_timeout", 32'(timeout_err_o), 32'd0);
    applyStimulus(idleStim());
    #3;
    checkOutput("mb_redirect", 32'(redirect_o), 32'd1);
    checkOutput("mb_redirect_pc", redirect_pc_o, 32'h200);
    applyStimulus(idleStim());
    #3;
    checkOutput("mb_single_redirect", 32'(redirect_o), 32'd0);

    $display("[TB] memory timeout");
    s = idleStim(); s.mem = 1;
    for (int i = 0; i < TO; i++) applyStimulus(s);
    applyStimulus(idleStim());
    #3;
    checkOutput("to_set", 32'(timeout_err_o), 32'd1);
    applyStimulus(idleStim());
    #3;
    checkOutput("to_sticky", 32'(timeout_err_o), 32'd1);
    s = idleStim(); s.rst = 1;
    applyStimulus(s);
    applyStimulus(idleStim());
    #3;
    checkOutput("to_cleared", 32'(timeout_err_o), 32'd0);

    $display("[TB] counter saturation");
    s = idleStim(); s.ifs = 1;
    for (int i = 0; i < 20; i++) applyStimulus(s);
    applyStimulus(idleStim());
    #3;
    checkOutput("sat_stall_cnt", 32'(stall_cnt_o), 32'(CMAX));
    checkOutput("sat_flush_cnt", 32'(flush_cnt_o), 32'(CMAX));

    $display("[TB] reset during redirect");
    s = idleStim(); s.br = 1; s.tgt = 32'h300;
    applyStimulus(s);
    s = idleStim(); s.rst = 1;
    applyStimulus(s);
    #3;
    checkOutput("rr_in_redir", 32'(state_o), 32'd2);
    checkOutput("rr_redirect_masked", 32'(redirect_o), 32'd0);
    applyStimulus(idleStim());
    #3;
    checkOutput("rr_state", 32'(state_o), 32'd0);
    checkOutput("rr_redirect", 32'(redirect_o), 32'd0);
    checkOutput("rr_pend_pc", redirect_pc_o, 32'd0);
    checkOutput("rr_stall_cnt", 32'(stall_cnt_o), 32'd0);
    applyStimulus(idleStim());
    #3;
    checkOutput("rr_no_late_redirect", 32'(redirect_o), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      s      = idleStim();
      s.rst  = ($urandom_range(99) < 2);
      s.mem  = ($urandom_range(99) < 15);
      s.br   = ($urandom_range(99) < 15);
      s.tgt  = $urandom();
      s.ifs  = ($urandom_range(99) < 25);
      s.ld   = 1'($urandom_range(1));
      s.wreg = 1'($urandom_range(1));
      s.wd   = 5'($urandom_range(3));
      s.r1rd = 1'($urandom_range(1));
      s.r2rd = 1'($urandom_range(1));
      s.a1   = 5'($urandom_range(3));
      s.a2   = 5'($urandom_range(3));
      applyStimulus(s);
    end
    applyStimulus(idleStim());
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, meaning max consecutive mem-stall cycles before timeout error.
REQ-002 Parameter CNT_W, default 16, meaning width of saturating performance counters.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_reg1_read, id_reg2_read  in  1 each  decode stage reads rs1/rs2.
REQ-006 id_reg1_addr, id_reg2_addr  in  5 each  decode source register addresses.
REQ-007 ex_is_load  in  1  instruction in EX is a LOAD; ex_wreg  in  1  EX writes rd; ex_wd  in  5  EX rd.
REQ-008 ex_branch_taken  in  1  EX resolved a taken branch/JAL/JALR; ex_branch_target  in  32  target PC.
REQ-009 if_req_stall  in  1  fetch not ready; mem_req_stall  in  1  data memory busy.
REQ-010 stall_o  out  6  hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (0).
REQ-011 flush_o  out  2  bubble vector: bit0 IF/ID, bit1 ID/EX.
REQ-012 redirect_o  out  1  PC load strobe; redirect_pc_o  out  32  PC to load.
REQ-013 state_o  out  2  current FSM state; timeout_err_o  out  1  sticky mem-timeout flag.
REQ-014 stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating counters.

Function
REQ-015 FSM states SHALL be RUN=0, MEMWAIT=1, REDIR=2, LDSTALL=3; state and counters registered, stall_o/flush_o/redirect outputs combinational from state, registers and inputs.
REQ-016 Load-use hazard SHALL be ex_is_load & ex_wreg & ex_wd!=0 & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)).
REQ-017 Per-cycle priority SHALL be: mem_req_stall > pending/new redirect > load-use > if_req_stall.
REQ-018 mem_req_stall=1 (any state): stall_o=6'b011111, flush_o=0, redirect_o=0; next state MEMWAIT.
REQ-019 ex_branch_taken=1 while mem_req_stall=1: target SHALL be latched into pend_pc and pend flag set; an already-set pend SHALL NOT be overwritten.
REQ-020 MEMWAIT with mem_req_stall=0: next state REDIR if pend=1, else RUN; outputs that cycle as RUN.
REQ-021 RUN with ex_branch_taken=1, no mem stall: flush_o=2'b11, stall_o=0, target latched into pend_pc, next state REDIR.
REQ-022 REDIR: redirect_o=1, redirect_pc_o=pend_pc, flush_o=2'b01, pend cleared, next state RUN; redirect_o SHALL be 1 for exactly one cycle per taken branch.
REQ-023 RUN with load-use (no mem stall, no branch): stall_o=6'b000011, flush_o=2'b10, next state LDSTALL.
REQ-024 LDSTALL SHALL return to RUN next cycle with stall_o=0 unless a higher-priority event applies; a repeated load-use match in LDSTALL is impossible and SHALL NOT restall.
REQ-025 RUN with only if_req_stall: stall_o=6'b000001, flush_o=2'b01; state remains RUN.
REQ-026 redirect_pc_o SHALL equal pend_pc whenever redirect_o=0.
REQ-027 stall_cnt_o SHALL increment each cycle stall_o!=0; flush_cnt_o each cycle flush_o!=0; both saturate at all-ones, no wrap.
REQ-028 Mem-stall run counter SHALL count consecutive mem_req_stall cycles, clear when it drops; reaching MEM_TIMEOUT SHALL set timeout_err_o, held until rst; counter saturates.
REQ-029 ex_branch_taken in REDIR or LDSTALL SHALL be ignored (pipeline already bubbled).

Reset
REQ-030 rst=1 at a clock edge SHALL force state RUN, pend=0, pend_pc=0, counters=0, timeout_err_o=0, overriding any in-progress stall or redirect.
REQ-031 During and after reset until inputs act: stall_o=0, flush_o=0, redirect_o=0, redirect_pc_o=0, state_o=0.

Verification
REQ-032 Load-use: ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 -> one cycle stall_o=000011, flush_o=10, state LDSTALL, then RUN with stall_o=0; ex_wd=0 -> no stall.
REQ-033 Branch: ex_branch_taken=1, target 0x00000100 in RUN -> flush_o=11 that cycle, next cycle redirect_o=1, redirect_pc_o=0x100, flush_o=01, then RUN.
REQ-034 Branch during mem stall: mem_req_stall=1 for 3 cycles, taken branch target 0x200 in cycle 1 -> stall_o=011111 for 3 cycles, no redirect, then RUN one cycle, then single redirect to 0x200.
REQ-035 Timeout: MEM_TIMEOUT=4, mem_req_stall held 4 cycles -> timeout_err_o=1 after 4th edge, remains 1 after stall drops until rst.
REQ-036 Counter saturation: CNT_W=4, if_req_stall held 20 cycles -> stall_cnt_o stops at 15.
REQ-037 Reset mid-REDIR: rst asserted in REDIR cycle -> next cycle state RUN, redirect_o=0, pend cleared, counters 0.
